// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : rv32i data-port stage. Turns one load/store request at a time into
//            a BRAM word access with byte-lane write mask and replicated store
//            data; returns extended load data after READ_LATENCY cycles.
//            Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned trap).
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int READ_LATENCY = 1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] addr_data,
    output logic [31:0] data_out_data,
    input  logic [31:0] data_in_data,
    output logic        en_data,
    output logic [3:0]  we_data
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_WAIT   = 2'd2;
    localparam logic [1:0] c_ST_RESP   = 2'd3;
    localparam logic [1:0] c_WAIT_INIT = 2'(READ_LATENCY - 1);

    logic [1:0]  r_state;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [1:0]  r_cnt;

    logic        w_legal;
    logic [3:0]  w_we;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    // Request decode: legality, lane mask and replicated store data.
    always_comb begin
        w_legal = 1'b0;
        if (req_store) begin
            w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                      (req_funct3 == 3'b010);
        end else begin
            w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                      (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                      (req_funct3 == 3'b101);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
            (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)) begin
            w_legal = 1'b0;
        end
`endif
        case (req_funct3[1:0])
            2'b00: begin
                w_we    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_we    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_we    = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

    // Load extraction from the latched low address bits and funct3.
    always_comb begin
        case (r_addr_lo)
            2'd0:    w_byte = data_in_data[7:0];
            2'd1:    w_byte = data_in_data[15:8];
            2'd2:    w_byte = data_in_data[23:16];
            default: w_byte = data_in_data[31:24];
        endcase
        w_half = r_addr_lo[1] ? data_in_data[31:16] : data_in_data[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = data_in_data;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= c_ST_IDLE;
            r_store       <= 1'b0;
            r_funct3      <= 3'd0;
            r_addr_lo     <= 2'd0;
            r_cnt         <= 2'd0;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= 32'd0;
            rsp_err       <= 1'b0;
            addr_data     <= 32'd0;
            data_out_data <= 32'd0;
            en_data       <= 1'b0;
            we_data       <= 4'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_store   <= req_store;
                        r_funct3  <= req_funct3;
                        r_addr_lo <= req_addr[1:0];
                        req_ready <= 1'b0;
                        rsp_rdata <= 32'd0;
                        if (w_legal) begin
                            r_state   <= c_ST_ACCESS;
                            rsp_err   <= 1'b0;
                            en_data   <= 1'b1;
                            addr_data <= {2'b00, req_addr[31:2]};
                            we_data   <= req_store ? w_we : 4'd0;
                            if (req_store) begin
                                data_out_data <= w_wdata;
                            end
                        end else begin
                            r_state   <= c_ST_RESP;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                c_ST_ACCESS: begin
                    en_data <= 1'b0;
                    we_data <= 4'd0;
                    if (r_store || READ_LATENCY == 1) begin
                        r_state   <= c_ST_RESP;
                        rsp_valid <= 1'b1;
                        if (!r_store) begin
                            rsp_rdata <= w_load_data;
                        end
                    end else begin
                        r_state <= c_ST_WAIT;
                        r_cnt   <= c_WAIT_INIT;
                    end
                end
                c_ST_WAIT: begin
                    // Count 1 marks the cycle in which the BRAM output is valid.
                    if (r_cnt == 2'd1) begin
                        r_state   <= c_ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= w_load_data;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        r_state   <= c_ST_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Self-checking bench for load_store_unit at READ_LATENCY 1 and 3,
//            with a BRAM model and an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam logic [31:0] c_JUNK = 32'h5A5A_C3C3;

    logic        clk = 1'b0;
    logic        areset;
    logic        mem_load;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_store [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err [2];
    logic [31:0] addr_data [2];
    logic [31:0] data_out_data [2];
    logic [31:0] data_in_data [2];
    logic        en_data [2];
    logic [3:0]  we_data [2];

    logic [31:0] mem [2][256];
    logic [31:0] init_mem [256];
    logic [31:0] ref_mem [2][256];
    logic [1:0]  en_pipe [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.READ_LATENCY(1)) u_dut0 (
        .aclk(clk), .areset(areset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_store(req_store[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .addr_data(addr_data[0]), .data_out_data(data_out_data[0]),
        .data_in_data(data_in_data[0]), .en_data(en_data[0]), .we_data(we_data[0])
    );

    load_store_unit #(.READ_LATENCY(3)) u_dut1 (
        .aclk(clk), .areset(areset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_store(req_store[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .addr_data(addr_data[1]), .data_out_data(data_out_data[1]),
        .data_in_data(data_in_data[1]), .en_data(en_data[1]), .we_data(we_data[1])
    );

    // BRAM model: byte-masked writes; read data valid only L-1 cycles after the enable.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_load) begin
                for (int i = 0; i < 256; i++) mem[d][i] <= init_mem[i];
            end else if (en_data[d]) begin
                for (int b = 0; b < 4; b++) begin
                    if (we_data[d][b]) mem[d][addr_data[d][7:0]][8*b +: 8] <= data_out_data[d][8*b +: 8];
                end
            end
            en_pipe[d] <= areset ? 2'b00 : {en_pipe[d][0], en_data[d]};
        end
    end

    always_comb begin
        data_in_data[0] = en_data[0]    ? mem[0][addr_data[0][7:0]] : c_JUNK;
        data_in_data[1] = en_pipe[1][1] ? mem[1][addr_data[1][7:0]] : c_JUNK;
    end

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: what one request should produce, from size/offset arithmetic.
    function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] word,
                                  output bit legal, output logic [31:0] rd,
                                  output logic [3:0] we, output logic [31:0] dout);
        int unsigned nbytes, off;
        longint unsigned mask, v, mult;
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        nbytes = 1 << f3[1:0];
        off = a % 4;
        off = off - (off % nbytes);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((a % nbytes) != 0) legal = 1'b0;
`endif
        mask = (nbytes >= 8) ? 64'hFFFF_FFFF : ((64'd1 << (8 * nbytes)) - 1);
        we = (legal && st) ? 4'(((1 << nbytes) - 1) << off) : 4'd0;
        mult = (nbytes == 1) ? 64'h0101_0101 : (nbytes == 2) ? 64'h0001_0001 : 64'd1;
        dout = 32'((longint'(wd) & mask) * mult);
        v = (longint'(word) >> (8 * off)) & mask;
        if (!st && !f3[2] && nbytes < 4 && v >= (mask + 1) / 2) v = v + (64'hFFFF_FFFF - mask);
        rd = (legal && !st) ? 32'(v) : 32'd0;
    endfunction

    task automatic txn(input int d, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int hold);
        bit legal;
        logic [31:0] erd, edout;
        logic [3:0] ewe;
        int exp_cyc;
        model(st, f3, a, wd, ref_mem[d][a[9:2]], legal, erd, ewe, edout);
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1; req_store[d] = st; req_funct3[d] = f3;
        req_addr[d] = a; req_wdata[d] = wd;
        @(negedge clk);
        req_valid[d] = 1'b0; req_store[d] = 1'($urandom); req_funct3[d] = 3'($urandom);
        req_addr[d] = $urandom; req_wdata[d] = $urandom;
        if (!legal) begin
            check("illegal_en", 32'(en_data[d]), 32'd0);
            check("illegal_valid", 32'(rsp_valid[d]), 32'd1);
            check("illegal_err", 32'(rsp_err[d]), 32'd1);
            check("illegal_rdata", rsp_rdata[d], 32'd0);
        end else begin
            check("access_en", 32'(en_data[d]), 32'd1);
            check("access_addr", addr_data[d], {2'b00, a[31:2]});
            check("access_we", 32'(we_data[d]), 32'(ewe));
            if (st) check("access_wdata", data_out_data[d], edout);
            check("access_valid", 32'(rsp_valid[d]), 32'd0);
            if (st) begin
                for (int b = 0; b < 4; b++)
                    if (ewe[b]) ref_mem[d][a[9:2]][8*b +: 8] = edout[8*b +: 8];
            end
            exp_cyc = st ? 2 : 2 + lat(d) - 1;
            for (int c = 2; c < exp_cyc; c++) begin
                @(negedge clk);
                check("wait_valid", 32'(rsp_valid[d]), 32'd0);
                check("wait_en", 32'(en_data[d]), 32'd0);
            end
            @(negedge clk);
            check("resp_valid", 32'(rsp_valid[d]), 32'd1);
            check("resp_err", 32'(rsp_err[d]), 32'd0);
            check("resp_rdata", rsp_rdata[d], erd);
            check("resp_en", 32'(en_data[d]), 32'd0);
        end
        // Hold the response while a second (legal) request is offered.
        for (int h = 0; h < hold; h++) begin
            req_valid[d] = 1'b1; req_store[d] = 1'b0; req_funct3[d] = 3'b010;
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid[d]), 32'd1);
            check("hold_req_ready", 32'(req_ready[d]), 32'd0);
            check("hold_en", 32'(en_data[d]), 32'd0);
            check("hold_rdata", rsp_rdata[d], erd);
            check("hold_err", 32'(rsp_err[d]), 32'(!legal));
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check("post_valid", 32'(rsp_valid[d]), 32'd0);
        check("post_req_ready", 32'(req_ready[d]), 32'd1);
        check("post_en", 32'(en_data[d]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        mem_load = 1'b1;
        for (int i = 0; i < 256; i++) init_mem[i] = $urandom;
        init_mem[16] = 32'h80F0_7F01;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) ref_mem[d][i] = init_mem[i];
            req_valid[d] = 1'b0; req_store[d] = 1'b0; req_funct3[d] = 3'd0;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        mem_load = 1'b0;
        areset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_req_ready", 32'(req_ready[d]), 32'd1);
            check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            check("rst_rsp_rdata", rsp_rdata[d], 32'd0);
            check("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
            check("rst_en", 32'(en_data[d]), 32'd0);
            check("rst_we", 32'(we_data[d]), 32'd0);
            check("rst_addr", addr_data[d], 32'd0);
            check("rst_dout", data_out_data[d], 32'd0);
        end

        // Directed cases
        txn(0, 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0);
        txn(0, 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 2);
        for (int d = 0; d < 2; d++) begin
            txn(d, 1'b0, 3'b000, 32'h0000_0043, 32'd0, 0);
            txn(d, 1'b0, 3'b100, 32'h0000_0043, 32'd0, 1);
            txn(d, 1'b0, 3'b001, 32'h0000_0042, 32'd0, 0);
            txn(d, 1'b0, 3'b101, 32'h0000_0040, 32'd0, 0);
            txn(d, 1'b0, 3'b011, 32'h0000_0040, 32'd0, 1);
            txn(d, 1'b1, 3'b100, 32'h0000_0040, 32'h1234_5678, 0);
            txn(d, 1'b0, 3'b010, 32'h0000_0102, 32'd0, 0);
            txn(d, 1'b1, 3'b001, 32'h0000_0023, 32'hCAFE_F00D, 0);
            txn(d, 1'b0, 3'b010, 32'h0000_0020, 32'd0, 0);
        end

        // Randomized traffic on a small window of words so stores feed later loads
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 7)) << 2);
            txn(n % 2, 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, $urandom_range(0, 3));
        end

        // Reset while a load response is pending with rsp_ready low
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            req_valid[d] = 1'b1; req_store[d] = 1'b0; req_funct3[d] = 3'b010;
            req_addr[d] = 32'h0000_0040;
            @(negedge clk);
            req_valid[d] = 1'b0;
            repeat (4) @(negedge clk);
            check("pre_rst_valid", 32'(rsp_valid[d]), 32'd1);
            areset = 1'b1;
            @(negedge clk);
            areset = 1'b0;
            check("post_rst_valid", 32'(rsp_valid[d]), 32'd0);
            check("post_rst_req_ready", 32'(req_ready[d]), 32'd1);
            check("post_rst_rdata", rsp_rdata[d], 32'd0);
            check("post_rst_en", 32'(en_data[d]), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Data-port stage of the rv32i core. It sits between the core's execute stage and the data BRAM port (`addr_data`/`data_out_data`/`data_in_data`/`en_data`/`we_data`). It accepts one load or store request at a time and converts the byte address and funct3 into a word address, a byte-lane write mask and lane-shifted write data. For loads it waits out the BRAM read latency, then returns the selected byte, half-word or word, sign- or zero-extended.

## Interface
Reset is synchronous, active-high.
- `READ_LATENCY`, default 1: BRAM read latency in cycles; legal values 1..3.

Ports:
- `aclk` in 1: the only clock.
- `areset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request (high only in IDLE).
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3 of the load/store.
- `req_addr` in 32: byte address (rs1 + imm, computed upstream).
- `req_wdata` in 32: rs2 value; store data in bits [7:0] / [15:0] / [31:0].
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: core consumes the response.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: illegal funct3 (or misaligned, see Configuration).
- `addr_data` out 32: word address `{2'b00, addr[31:2]}`.
- `data_out_data` out 32: lane-aligned store data.
- `data_in_data` in 32: BRAM read data.
- `en_data` out 1: BRAM enable.
- `we_data` out 4: byte write enables.

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch the request.
  - Legal request → ACCESS. Illegal request → RESP with `rsp_err` = 1; no memory access is made.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- ACCESS: exactly one cycle.
  - `en_data` = 1; `addr_data` driven.
  - Store:
    - `we_data` = SB: `4'b0001 << a[1:0]`; SH: `4'b0011 << a[1:0]` (a[0] ignored); SW: `4'b1111`.
    - `data_out_data` = wdata byte/half replicated to all lanes.
    - Next state: RESP.
  - Load: `we_data` = 0. Next state: WAIT if `READ_LATENCY` > 1, else capture data → RESP.
- WAIT: counter runs down from `READ_LATENCY`−1. `data_in_data` is captured in the cycle the counter reaches the last wait cycle, then → RESP.
- Load extraction:
  - Byte lane `a[1:0]`, half lane `a[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- RESP:
  - `rsp_valid` = 1; `rsp_rdata` and `rsp_err` are held stable.
  - Leaves for IDLE on `rsp_ready`.
- Outside ACCESS: `en_data` = 0, `we_data` = 0, `addr_data`/`data_out_data` hold their last value.

## Timing
- Reset values: `req_ready` = 1 (state IDLE), `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, `en_data` = 0, `we_data` = 0, `addr_data` = 0, `data_out_data` = 0.
- Request accepted at cycle 0 (`req_valid` & `req_ready`):
  - Memory port active in cycle 1.
  - Store: `rsp_valid` in cycle 2.
  - Load: `rsp_valid` in cycle 2 + (`READ_LATENCY` − 1).
  - Illegal request: `rsp_valid` in cycle 1.
- `rsp_valid` & `rsp_ready` in cycle N → `req_ready` = 1 in cycle N+1. There is no same-cycle response/request overlap.
- `rsp_ready` held low: the response stays indefinitely and no new request is accepted.
- `areset` in any state:
  - Returns to IDLE next cycle with the reset values above.
  - An in-flight store whose ACCESS cycle already occurred has been written; a pending load response is dropped.
- Request inputs are sampled only at acceptance; later changes are ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN`: misaligned-access trap compiled in or out.
- Defined:
  - LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]≠0, are illegal.
  - No memory access is made; `rsp_err` = 1, `rsp_rdata` = 0, response in cycle 1.
- Undefined:
  - The offending low address bits are ignored (half: a[0] treated as 0; word: a[1:0] treated as 00).
  - The access proceeds normally with `rsp_err` = 0.

## Test plan
- SW addr 0x104, wdata 0xDEADBEEF → cycle 1: `addr_data` = 0x41, `we_data` = 1111, `data_out_data` = 0xDEADBEEF; cycle 2: `rsp_valid`, `rsp_err` = 0.
- SB addr 0x203, wdata 0x000000A5 → `we_data` = 1000, `data_out_data` = 0xA5A5A5A5.
- Memory word 0x80F07F01 at 0x40:
  - LB 0x43 → 0xFFFFFF80; LBU 0x43 → 0x00000080.
  - LH 0x42 → 0xFFFF80F0; LHU 0x40 → 0x00007F01.
  - Repeat with `READ_LATENCY` = 1 and 3; check response cycle = 2 + L − 1.
- funct3 = 011 load → cycle 1: `rsp_err` = 1, `rsp_rdata` = 0, `en_data` never asserted.
- LW addr 0x102:
  - With the macro: `rsp_err` = 1, no access.
  - Without the macro: reads word 0x40, `rsp_err` = 0.
- Load accepted with `rsp_ready` low for 5 cycles, then `areset` pulsed → `rsp_valid` = 0 and `req_ready` = 1 the cycle after reset.
- Second request offered while in RESP → it is not accepted until the cycle after `rsp_ready`.
